// File: rtl/aes_pkg.sv
// Shared definitions for the AES round scheduler: round count, key-index width
// and the controller state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_IDX_W  = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEXP  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/aes_round_sched_if.sv
// Control bundle between the round scheduler (slave) and its user / datapath (master).
// Handshake: i_fStart is a request taken only while o_fBusy is low (IDLE); it is
// not queued. o_fDone / o_fErr are single-cycle completion pulses, no ready back-pressure.
interface aes_round_sched_if;
  import aes_pkg::*;

  logic                 i_fStart;
  logic                 i_fEnc;
  logic                 i_fNewKey;
  logic                 i_fKexpDone;
  logic                 o_fKexpStart;
  logic                 o_fLoad;
  logic                 o_fRoundEn;
  logic [KEY_IDX_W-1:0] o_RoundIdx;
  logic [KEY_IDX_W-1:0] o_KeySel;
  logic                 o_fFinal;
  logic                 o_fBusy;
  logic                 o_fDone;
  logic                 o_fErr;

  modport master (
    output i_fStart, i_fEnc, i_fNewKey, i_fKexpDone,
    input  o_fKexpStart, o_fLoad, o_fRoundEn, o_RoundIdx, o_KeySel,
           o_fFinal, o_fBusy, o_fDone, o_fErr
  );

  modport slave (
    input  i_fStart, i_fEnc, i_fNewKey, i_fKexpDone,
    output o_fKexpStart, o_fLoad, o_fRoundEn, o_RoundIdx, o_KeySel,
           o_fFinal, o_fBusy, o_fDone, o_fErr
  );

endinterface

// File: rtl/aes_round_ctr.sv
// Round counter: load to 1, increment, clear; tc flags the last round.
module aes_round_ctr #(
  parameter int W   = 4,
  parameter int MAX = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(MAX));

endmodule

// File: rtl/aes_round_sched.sv
// AES block controller: optional key expansion, initial key add, NUM_ROUNDS rounds,
// done pulse. All outputs are decoded from registered state only.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS   = aes_pkg::NUM_ROUNDS,
  parameter int KEXP_TIMEOUT = 63
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  aes_round_sched_if.slave        bus,
  output state_t                  fsm_state
);

  localparam int TW = (KEXP_TIMEOUT < 2) ? 1 : $clog2(KEXP_TIMEOUT + 1);

  state_t               state;
  logic                 key_valid;
  logic                 enc_q;
  logic [TW-1:0]        tmo_cnt;
  logic [KEY_IDX_W-1:0] round_cnt;
  logic                 round_tc;
  logic                 tmo_hit;

  assign fsm_state = state;
  assign tmo_hit   = (tmo_cnt == TW'(KEXP_TIMEOUT));

  aes_round_ctr #(
    .W   (KEY_IDX_W),
    .MAX (NUM_ROUNDS)
  ) u_round_ctr (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .load  (state == ST_LOAD),
    .inc   ((state == ST_ROUND) && !round_tc),
    .clr   ((state == ST_ROUND) && round_tc),
    .count (round_cnt),
    .tc    (round_tc)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      key_valid <= 1'b0;
      enc_q     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_fStart) begin
            enc_q   <= bus.i_fEnc;
            tmo_cnt <= '0;
            state   <= (bus.i_fNewKey || !key_valid) ? ST_KEXP : ST_LOAD;
          end
        end
        ST_KEXP: begin
          // Timeout wins over a done seen in the same cycle: the error pulse is already out.
          if (tmo_hit) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            tmo_cnt   <= '0;
          end else if (bus.i_fKexpDone) begin
            state     <= ST_LOAD;
            key_valid <= 1'b1;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_LOAD:  state <= ST_ROUND;
        ST_ROUND: if (round_tc) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_fKexpStart = 1'b0;
    bus.o_fLoad      = 1'b0;
    bus.o_fRoundEn   = 1'b0;
    bus.o_RoundIdx   = '0;
    bus.o_KeySel     = '0;
    bus.o_fFinal     = 1'b0;
    bus.o_fBusy      = (state != ST_IDLE);
    bus.o_fDone      = (state == ST_DONE);
    bus.o_fErr       = 1'b0;
    case (state)
      ST_KEXP: begin
        bus.o_fKexpStart = (tmo_cnt == '0);
        bus.o_fErr       = tmo_hit;
      end
      ST_LOAD: begin
        bus.o_fLoad  = 1'b1;
        bus.o_KeySel = enc_q ? '0 : KEY_IDX_W'(NUM_ROUNDS);
      end
      ST_ROUND: begin
        bus.o_fRoundEn = 1'b1;
        bus.o_RoundIdx = round_cnt;
        bus.o_KeySel   = enc_q ? round_cnt : (KEY_IDX_W'(NUM_ROUNDS) - round_cnt);
        bus.o_fFinal   = round_tc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized bench for aes_round_sched: per-cycle expected output trace from a
// behavioural model, popped and compared by an independent monitor.
module tb_aes_round_sched;
  import aes_pkg::*;

  localparam int NR = 10;
  localparam int TO = 63;
  localparam int W  = 15;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t fsm_state;

  always #5 clk = ~clk;

  aes_round_sched_if bus ();

  aes_round_sched #(
    .NUM_ROUNDS   (NR),
    .KEXP_TIMEOUT (TO)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           kv       = 1'b0;
  logic [W-1:0] got;
  logic [W-1:0] want;

  function automatic logic [W-1:0] pack(bit kst, bit ld, bit ren, int idx, int ks,
                                        bit fin, bit busy, bit done, bit err);
    return {kst, ld, ren, 4'(idx), 4'(ks), fin, busy, done, err};
  endfunction

  function automatic void check(string name, logic [W-1:0] g, logic [W-1:0] e);
    n_checks++;
    if (g === e) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, g, e);
  endfunction

  // Reference: the cycle-by-cycle output picture of one accepted operation.
  function automatic void push_trace(bit enc, bit kexp, int d, output int klen);
    int ncyc;
    klen = 0;
    if (kexp) begin
      ncyc = (d == 0) ? TO + 1 : d;
      for (int c = 1; c <= ncyc; c++)
        exp_q.push_back(pack(c == 1, 0, 0, 0, 0, 0, 1, 0, (d == 0) && (c == TO + 1)));
      klen = ncyc;
      if (d == 0) begin
        kv = 1'b0;
        return;
      end
      kv = 1'b1;
    end
    exp_q.push_back(pack(0, 1, 0, 0, enc ? 0 : NR, 0, 1, 0, 0));
    for (int r = 1; r <= NR; r++)
      exp_q.push_back(pack(0, 0, 1, r, enc ? r : NR - r, r == NR, 1, 0, 0));
    exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 1, 1, 0));
  endfunction

  // Monitor: every non-reset cycle, compare against the next expected entry (idle = all 0).
  always @(negedge clk) begin
    if (!rst) begin
      got = {bus.o_fKexpStart, bus.o_fLoad, bus.o_fRoundEn, bus.o_RoundIdx, bus.o_KeySel,
             bus.o_fFinal, bus.o_fBusy, bus.o_fDone, bus.o_fErr};
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check(bus.o_fBusy ? "busy_cycle" : "idle_cycle", got, want);
    end
  end

  task automatic idle(int n);
    bus.i_fStart = 1'b0;
    repeat (n) begin
      bus.i_fKexpDone = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // d: KEXP cycle in which done is raised (1-based), 0 = never.
  task automatic run_op(bit enc, bit newkey, int d, bit hold);
    int  klen;
    int  len;
    bit  kexp;
    kexp = newkey || !kv;
    bus.i_fStart    = 1'b1;
    bus.i_fEnc      = enc;
    bus.i_fNewKey   = newkey;
    bus.i_fKexpDone = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    push_trace(enc, kexp, d, klen);
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      bus.i_fStart  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.i_fEnc    = 1'($urandom_range(0, 1));
      bus.i_fNewKey = 1'($urandom_range(0, 1));
      if (i < klen) bus.i_fKexpDone = (d != 0) && (i == d - 1);
      else          bus.i_fKexpDone = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.i_fStart = 1'b0;
  endtask

  // Cached-key op reset during round 5; the following cycle must be fully idle.
  task automatic reset_mid();
    int klen;
    bus.i_fStart  = 1'b1;
    bus.i_fEnc    = 1'($urandom_range(0, 1));
    bus.i_fNewKey = 1'b0;
    @(posedge clk); #1;
    push_trace(bus.i_fEnc, 1'b0, 1, klen);
    for (int i = 0; i < 5; i++) begin
      bus.i_fStart    = 1'($urandom_range(0, 1));
      bus.i_fKexpDone = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst          = 1'b1;
    bus.i_fStart = 1'b0;
    exp_q.delete();
    kv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.i_fStart    = 1'b0;
    bus.i_fEnc      = 1'b0;
    bus.i_fNewKey   = 1'b0;
    bus.i_fKexpDone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    run_op(1'b1, 1'b0, 5, 1'b0);   // first start after reset expands the key
    idle(1);
    run_op(1'b1, 1'b0, 3, 1'b0);   // cached key, done 12 cycles after start edge
    idle(1);
    run_op(1'b0, 1'b0, 3, 1'b0);   // decrypt key order 10..0
    idle(1);
    run_op(1'b1, 1'b1, 2, 1'b0);   // forced re-expansion
    idle(1);
    run_op(1'b1, 1'b1, 0, 1'b0);   // expansion never finishes
    idle(1);
    run_op(1'b0, 1'b0, 4, 1'b0);   // key invalid after timeout -> re-expand
    idle(1);
    reset_mid();
    idle(1);
    run_op(1'b1, 1'b0, 6, 1'b0);   // key invalid after reset
    idle(1);
    run_op(1'b1, 1'b0, 1, 1'b1);   // start held high through three blocks
    run_op(1'b0, 1'b0, 1, 1'b1);
    run_op(1'b1, 1'b0, 1, 1'b1);
    idle(1);

    repeat (30) begin
      idle($urandom_range(0, 2));
      if (kv && $urandom_range(0, 7) == 0) begin
        reset_mid();
      end else begin
        run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8),
               1'($urandom_range(0, 1)));
      end
    end

    idle(3);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL trace_drained: got %0d leftover entries expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
